// File: rtl/turbofm_pkg.sv
// TurboFMpro shared definitions: config-port bit map, divisor defaults
// and the config-port write decoder.
package turbofm_pkg;

    localparam int CFG_YMSEL  = 0;
    localparam int CFG_YMSTAT = 1;
    localparam int CFG_SAASEL = 2;
    localparam int CFG_YMSLOW = 3;

    localparam int YM_DIV_FAST_DEF = 16;
    localparam int YM_DIV_SLOW_DEF = 32;
    localparam int SAA_DIV_DEF     = 7;

    typedef struct packed {
        logic ym_slow_req;
        logic saa_sel;
        logic ym_stat;
        logic ym_sel;
    } cfg_t;

    // Config bits are active-low on the host bus: 0xF is the idle setting.
    function automatic cfg_t cfg_decode(input logic [3:0] d);
        cfg_t c;
        c.ym_sel      = ~d[CFG_YMSEL];
        c.ym_stat     = ~d[CFG_YMSTAT];
        c.saa_sel     = ~d[CFG_SAASEL];
        c.ym_slow_req = ~d[CFG_YMSLOW];
        return c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_div.sv
// Integer clock divider with registered output; the divisor input is
// sampled only on the wrap cycle so period changes never glitch.
module clk_div #(
    parameter int MAX_DIV = 32,
    parameter int RST_DIV = MAX_DIV
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(MAX_DIV):0]   div_i,
    output logic                       wrap_o,
    output logic                       clk_o
);

    localparam int W = $clog2(MAX_DIV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] dm1_q;
    logic [W-1:0] dm1_d;
    logic [W:0]   half;
    logic         clk_q;
    logic         clk_d;

    // Divisor is held as div-1 so MAX_DIV itself fits in W bits.
    assign wrap_o = (cnt_q == dm1_q);

    always_comb begin
        cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        dm1_d = wrap_o ? W'(div_i - 1'b1) : dm1_q;
        half  = ({1'b0, dm1_q} + 1'b1) >> 1;
        clk_d = ({1'b0, cnt_q} < half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dm1_q <= W'(RST_DIV - 1);
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dm1_q <= dm1_d;
            clk_q <= clk_d;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/cfg_clkgen.sv
// TurboFMpro config-port register plus YM2203/SAA1099 clock generation.
// Define SAA_CLK_EN to build the SAA1099 clock divider and saa_sel select.
module cfg_clkgen
    import turbofm_pkg::*;
#(
    parameter int YM_DIV_FAST = YM_DIV_FAST_DEF,
    parameter int YM_DIV_SLOW = YM_DIV_SLOW_DEF,
    parameter int SAA_DIV     = SAA_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_port,
    input  logic [3:0] din,
    output logic       ym_sel,
    output logic       ym_stat,
    output logic       saa_sel,
    output logic       ym_slow,
    output logic       ymclk,
    output logic       saaclk
);

    localparam int YM_MAX = max2(YM_DIV_FAST, YM_DIV_SLOW);
    localparam int YDW    = $clog2(YM_MAX) + 1;

    if (YM_DIV_FAST < 2 || (YM_DIV_FAST % 2) != 0) begin : g_bad_fast
        $error("YM_DIV_FAST must be even and >= 2");
    end
    if (YM_DIV_SLOW < 2 || (YM_DIV_SLOW % 2) != 0) begin : g_bad_slow
        $error("YM_DIV_SLOW must be even and >= 2");
    end
    if (SAA_DIV < 2) begin : g_bad_saa
        $error("SAA_DIV must be >= 2");
    end

    cfg_t           cfg_q;
    cfg_t           cfg_d;
    logic           ym_slow_q;
    logic           ym_slow_d;
    logic           ym_wrap;
    logic [YDW-1:0] ym_div;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_port) begin
            cfg_d = cfg_decode(din);
        end
`ifndef SAA_CLK_EN
        cfg_d.saa_sel = 1'b0;
`endif
    end

    // Effective mode follows the request only at a YM period boundary.
    always_comb begin
        ym_slow_d = ym_wrap ? cfg_q.ym_slow_req : ym_slow_q;
        ym_div    = cfg_q.ym_slow_req ? YDW'(YM_DIV_SLOW)
                                      : YDW'(YM_DIV_FAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            ym_slow_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            ym_slow_q <= ym_slow_d;
        end
    end

    clk_div #(
        .MAX_DIV (YM_MAX),
        .RST_DIV (YM_DIV_FAST)
    ) u_ym_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_i  (ym_div),
        .wrap_o (ym_wrap),
        .clk_o  (ymclk)
    );

`ifdef SAA_CLK_EN
    localparam int SDW = $clog2(SAA_DIV) + 1;

    logic saa_wrap_unused;

    clk_div #(
        .MAX_DIV (SAA_DIV),
        .RST_DIV (SAA_DIV)
    ) u_saa_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_i  (SDW'(SAA_DIV)),
        .wrap_o (saa_wrap_unused),
        .clk_o  (saaclk)
    );
`else
    assign saaclk = 1'b0;
`endif

    assign ym_sel  = cfg_q.ym_sel;
    assign ym_stat = cfg_q.ym_stat;
    assign saa_sel = cfg_q.saa_sel;
    assign ym_slow = ym_slow_q;

endmodule

// File: tb/tb_cfg_clkgen.sv
// Randomized bench for cfg_clkgen against a period-level timeline model.
// Honours SAA_CLK_EN the same way as the design.
module tb_cfg_clkgen;

    localparam int FAST = 16;
    localparam int SLOW = 32;
    localparam int SAA  = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_port = 1'b0;
    logic [3:0] din = 4'h0;
    logic       ym_sel, ym_stat, saa_sel, ym_slow, ymclk, saaclk;
    logic [5:0] obs;
    logic [5:0] exp_v;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         e;
        logic [3:0] v;
    } wr_t;

    wr_t wq[$];

    cfg_clkgen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_port (wr_port),
        .din     (din),
        .ym_sel  (ym_sel),
        .ym_stat (ym_stat),
        .saa_sel (saa_sel),
        .ym_slow (ym_slow),
        .ymclk   (ymclk),
        .saaclk  (saaclk)
    );

    always #5 clk = ~clk;

    assign obs = {ym_sel, ym_stat, saa_sel, ym_slow, ymclk, saaclk};

    // Config nibble in force after edge e (0xF is the reset-equivalent value).
    function automatic logic [3:0] cfg_at(input int e);
        logic [3:0] r;
        r = 4'hF;
        foreach (wq[i]) begin
            if (wq[i].e <= e) r = wq[i].v;
        end
        return r;
    endfunction

    // Length of the ymclk period whose first high sample is r.
    function automatic int plen(input int r);
        logic [3:0] c;
        c = cfg_at(r - 2);
        return c[3] ? FAST : SLOW;
    endfunction

    function automatic int pstart(input int k);
        int r;
        r = 1;
        while (k >= r + plen(r)) r += plen(r);
        return r;
    endfunction

    function automatic logic [5:0] exp_vec(input int k);
        logic [3:0] c;
        logic       ym, slow, saa;
        int         r;
        c   = cfg_at(k);
        ym  = 1'b0;
        saa = 1'b0;
        if (k >= 1) begin
            r  = pstart(k);
            ym = (k - r) < plen(r) / 2;
        end
        slow = (plen(pstart(k + 1)) == SLOW);
`ifdef SAA_CLK_EN
        if (k >= 1) saa = ((k - 1) % SAA) < (SAA / 2);
        return {~c[0], ~c[1], ~c[2], slow, ym, saa};
`else
        return {~c[0], ~c[1], 1'b0, slow, ym, saa};
`endif
    endfunction

    task automatic tick(input logic wr, input logic [3:0] d);
        wr_port = wr;
        din     = d;
        @(posedge clk);
        cyc++;
        if (wr) wq.push_back('{e: cyc, v: d});
        @(negedge clk);
        wr_port = 1'b0;
        din     = 4'($urandom);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_port = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
        end
        wq.delete();
        cyc   = 0;
        rst_n = 1'b1;
        exp_v = exp_vec(0);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp_v);
        end
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 4'h0);
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_selects();
        logic [3:0] seq [5];
        seq = '{4'hE, 4'h9, 4'hB, 4'h6, 4'hF};
        for (int s = 0; s < 5; s++) begin
            tick(1'b1, seq[s]);
            for (int i = 0; i < 6; i++) begin
                exp_v = exp_vec(cyc);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL sel_%h cyc=%0d got=%b exp=%b",
                             seq[s], cyc, obs, exp_v);
                end
                tick(1'b0, 4'h0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 4'h0);
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sel_settle cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_mid_switch();
        int g;
        g = 0;
        while (cyc + 1 != pstart(cyc + 1) + 5 && g < 64) begin
            tick(1'b0, 4'h0);
            g++;
        end
        n_tests++;
        if (g >= 64) begin
            n_fail++;
            $display("FAIL mid_seek got=%0d need<%0d", g, 64);
        end
        tick(1'b1, 4'h7);
        for (int i = 0; i < 100; i++) begin
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_slow cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            tick(1'b0, 4'h0);
        end
        tick(1'b1, 4'hF);
        for (int i = 0; i < 80; i++) begin
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_fast cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            tick(1'b0, 4'h0);
        end
    endtask

    task automatic test_wrap_write();
        int g;
        g = 0;
        while (cyc + 2 != pstart(cyc + 2) && g < 64) begin
            tick(1'b0, 4'h0);
            g++;
        end
        n_tests++;
        if (g >= 64) begin
            n_fail++;
            $display("FAIL wrap_seek got=%0d need<%0d", g, 64);
        end
        tick(1'b1, 4'h7);
        for (int i = 0; i < 90; i++) begin
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_wr cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            tick(1'b0, 4'h0);
        end
        tick(1'b1, 4'hF);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 4'h0);
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_back cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int g;
        g = 0;
        while (cyc + 1 != pstart(cyc + 1) + 2 && g < 64) begin
            tick(1'b0, 4'h0);
            g++;
        end
        n_tests++;
        if (g >= 64) begin
            n_fail++;
            $display("FAIL b2b_seek got=%0d need<%0d", g, 64);
        end
        tick(1'b1, 4'h7);
        tick(1'b1, 4'hF);
        for (int i = 0; i < 64; i++) begin
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v || ym_slow !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            tick(1'b0, 4'h0);
        end
    endtask

    task automatic test_random();
        logic w;
        for (int i = 0; i < 600; i++) begin
            w = ($urandom_range(0, 7) == 0);
            tick(w, 4'($urandom));
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        tick(1'b1, 4'h0);
        g = 0;
        while (!(cyc >= 1 && cyc == pstart(cyc) + 2 && plen(pstart(cyc)) == SLOW)
               && g < 96) begin
            tick(1'b0, 4'h0);
            g++;
        end
        n_tests++;
        if (g >= 96) begin
            n_fail++;
            $display("FAIL rstmid_seek got=%0d need<%0d", g, 96);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_async got=%b exp=%b", obs, 6'b0);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_hold got=%b exp=%b", obs, 6'b0);
        end
        wq.delete();
        cyc   = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            exp_v = exp_vec(cyc);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rst_rerun cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            end
            tick(1'b0, 4'h0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_selects();
        test_mid_switch();
        test_wrap_write();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
